// File: rtl/counter_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_cmd_seq_if
// Description : Command bus between a command source and counter_cmd_seq.
//               Carries one timed counter command per valid/ready handshake.
//   cmd_valid   source -> sequencer  command present
//   cmd_ready   sequencer -> source  command FIFO can accept
//   cmd_op      source -> sequencer  00 HOLD, 01 UP, 10 DOWN, 11 LOAD
//   cmd_len     source -> sequencer  repeat count minus one
//   cmd_data    source -> sequencer  load value (LOAD only)
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_cmd_seq_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic [3:0]       cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_len,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_len,
        input  cmd_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : counter_cmd_seq
// Description : Command sequencer for the 4-bit up/down/load counter. Timed
//               commands are buffered in a DEPTH-entry FIFO and each one
//               drives the counter's en/dir/in/data inputs from registers
//               for cmd_len+1 cycles.
//   clk, rst_n  clock, asynchronous active-low reset
//   cmd         command bus (slave side): valid/ready, op, len, data
//   abort       synchronous flush of FIFO and the running command
//   en/dir/in   counter enable, direction (1 up), load select
//   data        counter load value
//   busy        running a command or FIFO non-empty
//   done        one-cycle pulse after a command's final cycle
// Revision    : 1.0 - initial release
// ============================================================================
module counter_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    counter_cmd_seq_if.slave       cmd,
    input  logic                   abort,
    output logic                   en,
    output logic                   dir,
    output logic                   in,
    output logic [3:0]             data,
    output logic                   busy,
    output logic                   done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + LEN_W + 4;
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [1:0]  C_OP_HOLD = 2'b00;
    localparam logic [1:0]  C_OP_UP   = 2'b01;
    localparam logic [1:0]  C_OP_LOAD = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    state_t           r_state;
    logic [LEN_W-1:0] r_remaining;
    logic             r_en;
    logic             r_dir;
    logic             r_in;
    logic [3:0]       r_data;
    logic             r_done;

    logic             w_ready;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [EW-1:0]    w_head;
    logic [1:0]       w_head_op;
    logic [LEN_W-1:0] w_head_len;
    logic [3:0]       w_head_data;

    // Ready comes from the count held at the start of the cycle, so a full
    // FIFO refuses a push even when it is popped in the same cycle.
    assign w_ready     = (r_count != C_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = cmd.cmd_valid & w_ready & ~abort;
    // Pop on entry from IDLE or on the last cycle of a running command, which
    // chains commands with no idle cycle between them.
    assign w_pop       = ~abort & ~w_empty &
                         ((r_state == S_IDLE) | (r_remaining == '0));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[EW-1 -: 2];
    assign w_head_len  = w_head[4 +: LEN_W];
    assign w_head_data = w_head[3:0];

    assign cmd.cmd_ready = w_ready;
    assign en            = r_en;
    assign dir           = r_dir;
    assign in            = r_in;
    assign data          = r_data;
    assign done          = r_done;
    assign busy          = (r_state == S_RUN) | ~w_empty;

    // Storage has no reset: entries are only read once the count says valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.cmd_op, cmd.cmd_len, cmd.cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_en        <= 1'b0;
            r_dir       <= 1'b0;
            r_in        <= 1'b0;
            r_data      <= 4'b0000;
            r_done      <= 1'b0;
        end else if (abort) begin
            // Flush everything except the last load value.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_en        <= 1'b0;
            r_dir       <= 1'b0;
            r_in        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end

            r_done <= 1'b0;
            if (w_pop) begin
                r_en        <= (w_head_op != C_OP_HOLD);
                r_in        <= (w_head_op == C_OP_LOAD);
                r_dir       <= (w_head_op == C_OP_UP);
                r_remaining <= w_head_len;
                r_state     <= S_RUN;
                if (w_head_op == C_OP_LOAD) begin
                    r_data <= w_head_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_pop) begin
                        r_en  <= 1'b0;
                        r_in  <= 1'b0;
                        r_dir <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_remaining != '0) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                    end else begin
                        r_done <= 1'b1;
                        if (!w_pop) begin
                            r_state <= S_IDLE;
                            r_en    <= 1'b0;
                            r_in    <= 1'b0;
                            r_dir   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_cmd_seq
// Description : Self-checking bench for counter_cmd_seq. A table of single
//               commands feeds a cycle-by-cycle expectation queue; hand-written
//               sequences cover chaining, FIFO full, abort and async reset.
//               A behavioural 4-bit counter sits on the sequencer outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       d_en;
    logic       d_dir;
    logic       d_in;
    logic [3:0] d_data;
    logic       d_busy;
    logic       d_done;
    logic       cnt_clr;
    logic [3:0] cnt;

    counter_cmd_seq_if #(.LEN_W(4)) cmd_if ();

    counter_cmd_seq #(.DEPTH(4), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd_if),
        .abort (abort),
        .en    (d_en),
        .dir   (d_dir),
        .in    (d_in),
        .data  (d_data),
        .busy  (d_busy),
        .done  (d_done)
    );

    always #5 clk = ~clk;

    // Counter being driven by the sequencer.
    always_ff @(posedge clk) begin
        if (cnt_clr)   cnt <= 4'd0;
        else if (d_en) cnt <= d_in ? d_data : (d_dir ? cnt + 4'd1 : cnt - 4'd1);
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] len;
        logic [3:0] cdata;
        logic       e_en;
        logic       e_dir;
        logic       e_in;
        logic [3:0] e_data;
    } vec_t;

    typedef struct packed {
        logic       en;
        logic       dir;
        logic       ld;
        logic [3:0] data;
        logic       done;
        logic       busy;
    } rec_t;

    rec_t sb[$];
    vec_t vt[8];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [3:0] cur_data;
    logic flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_push(input logic e, input logic d, input logic l,
                            input logic [3:0] dt, input logic dn, input logic b);
        rec_t r;
        r.en = e; r.dir = d; r.ld = l; r.data = dt; r.done = dn; r.busy = b;
        sb.push_back(r);
    endtask

    // Advance to the next falling edge and score one expected cycle if any.
    task automatic step();
        rec_t r;
        rec_t a;
        @(negedge clk);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            a.en = d_en; a.dir = d_dir; a.ld = d_in; a.data = d_data;
            a.done = d_done; a.busy = d_busy;
            check("sb{en,dir,in,data,done,busy}", 32'(a), 32'(r));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expected cycles left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] len, input logic [3:0] dt);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_len   = len;
        cmd_if.cmd_data  = dt;
    endtask

    initial begin
        //        op     len    cdata   en    dir   in    data
        vt[0] = '{2'b11, 4'd0,  4'hA,  1'b1, 1'b0, 1'b1, 4'hA};
        vt[1] = '{2'b01, 4'd2,  4'h5,  1'b1, 1'b1, 1'b0, 4'hA};
        vt[2] = '{2'b10, 4'd1,  4'hF,  1'b1, 1'b0, 1'b0, 4'hA};
        vt[3] = '{2'b00, 4'd0,  4'h3,  1'b0, 1'b0, 1'b0, 4'hA};
        vt[4] = '{2'b11, 4'd3,  4'h5,  1'b1, 1'b0, 1'b1, 4'h5};
        vt[5] = '{2'b01, 4'd15, 4'h0,  1'b1, 1'b1, 1'b0, 4'h5};
        vt[6] = '{2'b11, 4'd1,  4'h0,  1'b1, 1'b0, 1'b1, 4'h0};
        vt[7] = '{2'b10, 4'd0,  4'h9,  1'b1, 1'b0, 1'b0, 4'h0};

        // Reset with a command pending on the bus.
        rst_n = 1'b0;
        abort = 1'b0;
        cnt_clr = 1'b1;
        drive(2'b11, 4'd0, 4'hF);
        #12;
        check("reset outputs {en,dir,in,data,ready,busy,done}",
              32'({d_en, d_dir, d_in, d_data, cmd_if.cmd_ready, d_busy, d_done}),
              32'({3'b000, 4'h0, 1'b1, 1'b0, 1'b0}));
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) step();
        check("post-reset busy", 32'(d_busy), 32'd0);
        check("post-reset ready", 32'(cmd_if.cmd_ready), 32'd1);
        cur_data = 4'h0;

        // Single commands from an empty, idle sequencer.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].op, vt[i].len, vt[i].cdata);
            exp_push(1'b0, 1'b0, 1'b0, cur_data, 1'b0, 1'b1);
            for (int k = 0; k <= int'(vt[i].len); k++)
                exp_push(vt[i].e_en, vt[i].e_dir, vt[i].e_in, vt[i].e_data, 1'b0, 1'b1);
            exp_push(1'b0, 1'b0, 1'b0, vt[i].e_data, 1'b1, 1'b0);
            exp_push(1'b0, 1'b0, 1'b0, vt[i].e_data, 1'b0, 1'b0);
            cur_data = vt[i].e_data;
            step();
            cmd_if.cmd_valid = 1'b0;
            drain();
            if (vt[i].op == 2'b11) check("counter after LOAD", 32'(cnt), 32'(vt[i].cdata));
        end

        // Back-to-back UP len=2 then DOWN len=1, counter from 0.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(2'b01, 4'd2, 4'h0);
        exp_push(1'b0, 1'b0, 1'b0, cur_data, 1'b0, 1'b1);
        step();
        drive(2'b10, 4'd1, 4'h0);
        repeat (3) exp_push(1'b1, 1'b1, 1'b0, cur_data, 1'b0, 1'b1);
        exp_push(1'b1, 1'b0, 1'b0, cur_data, 1'b1, 1'b1);
        exp_push(1'b1, 1'b0, 1'b0, cur_data, 1'b0, 1'b1);
        exp_push(1'b0, 1'b0, 1'b0, cur_data, 1'b1, 1'b0);
        exp_push(1'b0, 1'b0, 1'b0, cur_data, 1'b0, 1'b0);
        step();
        cmd_if.cmd_valid = 1'b0;
        repeat (3) step();
        check("counter after UP x3", 32'(cnt), 32'd3);
        drain();
        check("counter after DOWN x2", 32'(cnt), 32'd1);

        // Fill the FIFO behind a long UP.
        drive(2'b01, 4'd15, 4'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 4'd15, 4'h0);
            step();
        end
        check("ready after 4th push", 32'(cmd_if.cmd_ready), 32'd0);
        drive(2'b11, 4'd0, 4'h7);
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cmd_if.cmd_ready !== 1'b0 || d_en !== 1'b1) flag = 1'b1;
        end
        check("full: ready low while UP runs", 32'(flag), 32'd0);
        step();
        check("ready after pop", 32'(cmd_if.cmd_ready), 32'd1);
        check("HOLD follows UP", 32'({d_en, d_busy}), 32'({1'b0, 1'b1}));
        step();
        check("5th accepted only now", 32'(cmd_if.cmd_ready), 32'd0);

        // Abort a full FIFO with a command on the bus in the same cycle.
        drive(2'b11, 4'd0, 4'h9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        check("abort full {en,dir,in,data,done,busy,ready}",
              32'({d_en, d_dir, d_in, d_data, d_done, d_busy, cmd_if.cmd_ready}),
              32'({3'b000, cur_data, 1'b0, 1'b0, 1'b1}));
        repeat (3) step();
        check("abort dropped same-cycle push", 32'({d_busy, d_data}), 32'({1'b0, cur_data}));

        // Abort mid-UP with two entries queued; data must survive.
        drive(2'b11, 4'd0, 4'hC);
        exp_push(1'b0, 1'b0, 1'b0, cur_data, 1'b0, 1'b1);
        exp_push(1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1);
        exp_push(1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b0);
        exp_push(1'b0, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0);
        step();
        cmd_if.cmd_valid = 1'b0;
        drain();
        drive(2'b01, 4'd8, 4'h0);
        step();
        drive(2'b00, 4'd2, 4'h0);
        step();
        drive(2'b10, 4'd3, 4'h0);
        step();
        cmd_if.cmd_valid = 1'b0;
        repeat (2) step();
        check("mid-UP before abort {en,dir,busy}", 32'({d_en, d_dir, d_busy}), 32'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort mid-UP {en,dir,in,data,done,busy,ready}",
              32'({d_en, d_dir, d_in, d_data, d_done, d_busy, cmd_if.cmd_ready}),
              32'({3'b000, 4'hC, 1'b0, 1'b0, 1'b1}));
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (d_done !== 1'b0 || d_en !== 1'b0 || d_busy !== 1'b0) flag = 1'b1;
        end
        check("no activity after abort", 32'(flag), 32'd0);

        // Asynchronous reset between edges while running.
        drive(2'b01, 4'd10, 4'h0);
        step();
        cmd_if.cmd_valid = 1'b0;
        repeat (3) step();
        check("running before reset", 32'({d_en, d_dir, d_busy}), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset {en,dir,in,data,busy,done,ready}",
              32'({d_en, d_dir, d_in, d_data, d_busy, d_done, cmd_if.cmd_ready}),
              32'({3'b000, 4'h0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        check("idle after reset release", 32'({d_en, d_busy}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
